// File: rtl/add_n_pkg.sv
// rtl/add_n_pkg.sv - shared types and helpers for the multi-cycle chunked adder
package add_n_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width for NCHUNK chunks; never narrower than one bit.
  function automatic int cnt_width(input int nchunk);
    if (nchunk <= 1) return 1;
    return $clog2(nchunk);
  endfunction

endpackage

// File: rtl/add_n_seq_if.sv
// rtl/add_n_seq_if.sv - operand/result handshake bundle for add_n_seq
interface add_n_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             sub_i;
  logic             cin_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_o;
  logic             cout_o;
  logic             ovf_o;
  logic             zero_o;

  modport slave (
    input  in_valid_i, a_i, b_i, sub_i, cin_i, out_ready_i,
    output in_ready_o, out_valid_o, out_o, cout_o, ovf_o, zero_o
  );

  modport master (
    output in_valid_i, a_i, b_i, sub_i, cin_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_o, cout_o, ovf_o, zero_o
  );
endinterface

// File: rtl/add_chunk.sv
// rtl/add_chunk.sv - combinational W-bit ripple adder built from full adders
module add_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         c_top_o
);

  // Ripple the carry bit by bit; c_top_o is the carry entering bit W-1,
  // which the top level needs for signed overflow on the last chunk.
  always_comb begin
    logic carry;
    sum_o   = '0;
    c_top_o = 1'b0;
    carry   = cin_i;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) c_top_o = carry;
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (a_i[i] & carry) | (b_i[i] & carry);
    end
    cout_o = carry;
  end

endmodule

// File: rtl/add_n_seq.sv
// rtl/add_n_seq.sv - multi-cycle WIDTH-bit add/sub, one CHUNK per clock, LSB first
module add_n_seq
  import add_n_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  add_n_seq_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);

  generate
    if (CHUNK < 1 || NCHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("add_n_seq: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end
  endgenerate

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout;
  logic             ch_ctop;
  logic             last_chunk;

  // Operands shift right each RUN cycle, so the active chunk is always the low bits.
  add_chunk #(.W(CHUNK)) u_chunk (
    .a_i     (a_q[CHUNK-1:0]),
    .b_i     (b_q[CHUNK-1:0]),
    .cin_i   (carry_q),
    .sum_o   (ch_sum),
    .cout_o  (ch_cout),
    .c_top_o (ch_ctop)
  );

  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

  // Next-state, datapath and flag computation; everything holds by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    res_d   = res_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          a_d     = bus.a_i;
          b_d     = bus.sub_i ? ~bus.b_i : bus.b_i;
          carry_d = bus.sub_i ? 1'b1 : bus.cin_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // New chunk enters at the top; after NCHUNK shifts chunk 0 sits at the LSBs.
        res_d   = WIDTH'({ch_sum, res_q} >> CHUNK);
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = ch_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last_chunk) begin
          out_d   = res_d;
          cout_d  = ch_cout;
          ovf_d   = ch_ctop ^ ch_cout;
          zero_d  = ~|res_d;
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.out_o       = out_q;
  assign bus.cout_o      = cout_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.zero_o      = zero_q;

endmodule

// File: tb/tb_add_n_seq.sv
// tb/tb_add_n_seq.sv - scoreboard bench for add_n_seq, WIDTH=16 CHUNK=4
module tb_add_n_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_n_seq_if #(.WIDTH(16)) bus ();

  add_n_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h with empty scoreboard", bus.out_o);
      end else begin
        mon_e = sb.pop_front();
        chk("out_o",  bus.out_o,  mon_e.res);
        chk("cout_o", bus.cout_o, mon_e.c);
        chk("ovf_o",  bus.ovf_o,  mon_e.o);
        chk("zero_o", bus.zero_o, mon_e.z);
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic c, input exp_t e, input bit expect_result);
    int n = 0;
    while (!bus.in_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_issue", bus.in_ready_o, 1);
    bus.a_i        = a;
    bus.b_i        = b;
    bus.sub_i      = s;
    bus.cin_i      = c;
    bus.in_valid_i = 1'b1;
    if (expect_result) sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    bus.a_i        = ~a;
    bus.b_i        = ~b;
    bus.sub_i      = ~s;
    bus.cin_i      = ~c;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid_o && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic c, input exp_t e);
    int cyc;
    issue(a, b, s, c, e, 1'b1);
    wait_valid(cyc);
    chk("latency", cyc, 4);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid_o, 0);
    chk({tag, "_out_o"},     bus.out_o,       0);
    chk({tag, "_cout"},      bus.cout_o,      0);
    chk({tag, "_ovf"},       bus.ovf_o,       0);
    chk({tag, "_zero"},      bus.zero_o,      0);
    chk({tag, "_in_ready"},  bus.in_ready_o,  1);
  endtask

  initial begin
    int cyc;
    int seen;
    bus.in_valid_i  = 1'b0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.sub_i       = 1'b0;
    bus.cin_i       = 1'b0;
    bus.out_ready_i = 1'b1;

    #2;
    chk_reset_outputs("por");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{res: 16'h0000, c: 1'b1, o: 1'b0, z: 1'b1});
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{res: 16'h8000, c: 1'b0, o: 1'b1, z: 1'b0});
    run_op(16'hAAAA, 16'h3BF1, 1'b0, 1'b1, '{res: 16'hE69C, c: 1'b0, o: 1'b0, z: 1'b0});
    run_op(16'h1234, 16'h9876, 1'b1, 1'b0, '{res: 16'h79BE, c: 1'b0, o: 1'b0, z: 1'b0});
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, '{res: 16'h0000, c: 1'b1, o: 1'b0, z: 1'b1});

    // Backpressure: 0x8000 - 0x0001 with cin=1 (ignored for subtract).
    bus.out_ready_i = 1'b0;
    issue(16'h8000, 16'h0001, 1'b1, 1'b1, '{res: 16'h7FFF, c: 1'b1, o: 1'b1, z: 1'b0}, 1'b1);
    wait_valid(cyc);
    chk("latency_bp", cyc, 4);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid_i = (i % 2 == 0);
      bus.a_i        = 16'h1111;
      bus.b_i        = 16'h2222;
      bus.sub_i      = 1'b0;
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid_o, 1);
      chk("bp_out_o",     bus.out_o,       16'h7FFF);
      chk("bp_cout",      bus.cout_o,      1);
      chk("bp_ovf",       bus.ovf_o,       1);
      chk("bp_zero",      bus.zero_o,      0);
      chk("bp_in_ready",  bus.in_ready_o,  0);
      @(posedge clk); #1;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready",  bus.in_ready_o,  1);
    chk("release_out_valid", bus.out_valid_o, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid_o) seen++;
    end
    chk("ignored_pulses_no_result", seen, 0);
    @(posedge clk); #1;

    // Asynchronous reset two cycles into RUN aborts the operation.
    issue(16'h5555, 16'h1111, 1'b0, 1'b0, '{res: 16'h6666, c: 1'b0, o: 1'b0, z: 1'b0}, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_run");
    #3 rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid_o) seen++;
    end
    chk("abort_no_result", seen, 0);
    @(posedge clk); #1;

    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, '{res: 16'h0007, c: 1'b0, o: 1'b0, z: 1'b0});

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
